// File: rtl/glb_banked_acc_unit_if.sv
// Bus bundle for glb_banked_acc_unit: wide line port A, per-bank element read port B,
// and the read-add-write accumulate port C.
interface glb_banked_acc_unit_if #(
    parameter int FIFO_WIDTH = 64,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 64
);
    localparam int LANES  = FIFO_WIDTH / DATA_WIDTH;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int AW     = $clog2(BANK_DEPTH);
    localparam int LW     = $clog2(BANK_DEPTH / LANES);

    logic                            a_valid;
    logic                            a_ready;
    logic                            a_we;
    logic [BANK_W-1:0]               a_bank;
    logic [LW-1:0]                   a_line;
    logic [FIFO_WIDTH-1:0]           a_wdata;
    logic                            a_rvalid;
    logic [FIFO_WIDTH-1:0]           a_rdata;
    logic [NUM_BANKS-1:0]            re_b;
    logic [NUM_BANKS*AW-1:0]         addr_b;
    logic [NUM_BANKS-1:0]            rvalid_b;
    logic [NUM_BANKS*DATA_WIDTH-1:0] rdata_b;
    logic                            c_valid;
    logic                            c_first;
    logic [BANK_W-1:0]               c_bank;
    logic [AW-1:0]                   c_addr;
    logic [DATA_WIDTH-1:0]           c_data;
    logic                            c_busy;

    modport master (
        output a_valid, a_we, a_bank, a_line, a_wdata, re_b, addr_b,
               c_valid, c_first, c_bank, c_addr, c_data,
        input  a_ready, a_rvalid, a_rdata, rvalid_b, rdata_b, c_busy
    );

    modport slave (
        input  a_valid, a_we, a_bank, a_line, a_wdata, re_b, addr_b,
               c_valid, c_first, c_bank, c_addr, c_data,
        output a_ready, a_rvalid, a_rdata, rvalid_b, rdata_b, c_busy
    );
endinterface

// File: rtl/glb_banked_acc_unit.sv
// Banked global buffer: line load/drain port A, per-bank element reads on B, and a two-stage
// saturating accumulate pipeline on C with write-back forwarding.
module glb_banked_acc_unit #(
    parameter int FIFO_WIDTH = 64,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    glb_banked_acc_unit_if.slave bus
);
    localparam int DW     = DATA_WIDTH;
    localparam int LANES  = FIFO_WIDTH / DATA_WIDTH;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int AW     = $clog2(BANK_DEPTH);
    localparam logic [BANK_W:0] NB_L    = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [DW-1:0]   SAT_MAX = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0]   SAT_MIN = {1'b1, {(DW - 1){1'b0}}};

    logic [DW-1:0] mem_q [NUM_BANKS][BANK_DEPTH];

    logic                    rdy_q;
    logic                    a_rvalid_q;
    logic [FIFO_WIDTH-1:0]   a_rdata_q;
    logic [NUM_BANKS-1:0]    rvalid_b_q;
    logic [NUM_BANKS*DW-1:0] rdata_b_q;

    logic              c1_valid_q, c1_first_q;
    logic [BANK_W-1:0] c1_bank_q;
    logic [AW-1:0]     c1_addr_q;
    logic [DW-1:0]     c1_data_q, c1_rd_q;
    logic              c2_valid_q, c2_first_q;
    logic [BANK_W-1:0] c2_bank_q;
    logic [AW-1:0]     c2_addr_q;
    logic [DW-1:0]     c2_data_q, c2_op_q;

    logic          a_bank_ok, c_bank_ok, a_ready_d, a_fire, c_in_hit, c1_hit;
    logic [AW-1:0] line_base;
    logic [DW:0]   c2_sum;
    logic [DW-1:0] c2_res, c1_op_d;

    assign a_bank_ok = {1'b0, bus.a_bank} < NB_L;
    assign c_bank_ok = {1'b0, bus.c_bank} < NB_L;
    assign a_ready_d = rdy_q && !(c2_valid_q && (c2_bank_q == bus.a_bank));
    assign a_fire    = bus.a_valid && a_ready_d && a_bank_ok;
    assign line_base = AW'(int'(bus.a_line) * LANES);

    assign c2_sum = {c2_op_q[DW-1], c2_op_q} + {c2_data_q[DW-1], c2_data_q};

    always_comb begin
        c2_res = c2_sum[DW-1:0];
        if (c2_first_q)
            c2_res = c2_data_q;
        else if (c2_sum[DW] != c2_sum[DW-1])
            c2_res = c2_sum[DW] ? SAT_MIN : SAT_MAX;
    end

    // Both hazards on the element C2 is writing: a request entering C1 this edge (its memory
    // read would miss the write) and a request already sitting in C1 (it read before the write).
    assign c_in_hit = c2_valid_q && (c2_bank_q == bus.c_bank) && (c2_addr_q == bus.c_addr);
    assign c1_hit   = c2_valid_q && (c2_bank_q == c1_bank_q) && (c2_addr_q == c1_addr_q);
    assign c1_op_d  = c1_hit ? c2_res : c1_rd_q;

    always_ff @(posedge clk) begin
        if (a_fire && bus.a_we)
            for (int k = 0; k < LANES; k++)
                mem_q[bus.a_bank][line_base + AW'(k)] <= bus.a_wdata[k*DW +: DW];
        if (c2_valid_q)
            mem_q[c2_bank_q][c2_addr_q] <= c2_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b0;
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            rvalid_b_q <= '0;
            rdata_b_q  <= '0;
            c1_valid_q <= 1'b0;
            c1_first_q <= 1'b0;
            c1_bank_q  <= '0;
            c1_addr_q  <= '0;
            c1_data_q  <= '0;
            c1_rd_q    <= '0;
            c2_valid_q <= 1'b0;
            c2_first_q <= 1'b0;
            c2_bank_q  <= '0;
            c2_addr_q  <= '0;
            c2_data_q  <= '0;
            c2_op_q    <= '0;
        end else begin
            rdy_q      <= 1'b1;
            rvalid_b_q <= bus.re_b;
            for (int i = 0; i < NUM_BANKS; i++)
                if (bus.re_b[i])
                    rdata_b_q[i*DW +: DW] <= mem_q[i][bus.addr_b[i*AW +: AW]];
            a_rvalid_q <= a_fire && !bus.a_we;
            if (a_fire && !bus.a_we)
                for (int k = 0; k < LANES; k++)
                    a_rdata_q[k*DW +: DW] <= mem_q[bus.a_bank][line_base + AW'(k)];

            c1_valid_q <= bus.c_valid && c_bank_ok;
            if (bus.c_valid && c_bank_ok) begin
                c1_first_q <= bus.c_first;
                c1_bank_q  <= bus.c_bank;
                c1_addr_q  <= bus.c_addr;
                c1_data_q  <= bus.c_data;
                c1_rd_q    <= c_in_hit ? c2_res : mem_q[bus.c_bank][bus.c_addr];
            end
            c2_valid_q <= c1_valid_q;
            if (c1_valid_q) begin
                c2_first_q <= c1_first_q;
                c2_bank_q  <= c1_bank_q;
                c2_addr_q  <= c1_addr_q;
                c2_data_q  <= c1_data_q;
                c2_op_q    <= c1_op_d;
            end
        end
    end

    assign bus.a_ready  = a_ready_d;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.c_busy   = c1_valid_q | c2_valid_q;
endmodule

// File: tb/tb_glb_banked_acc_unit.sv
// Directed plus randomized bench for glb_banked_acc_unit against an element-level memory model.
module tb_glb_banked_acc_unit;
    localparam int DW = 16, NB = 4, DEPTH = 64, LANES = 4, AW = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] mdl [NB][DEPTH];

    glb_banked_acc_unit_if bus_if ();

    glb_banked_acc_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] m, input logic [DW-1:0] d);
        int s;
        logic [31:0] r;
        s = int'($signed(m)) + int'($signed(d));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        r = 32'(s);
        return r[DW-1:0];
    endfunction

    function automatic logic [63:0] mline(input int b, input int l);
        logic [63:0] v;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = mdl[b][l*LANES + k];
        return v;
    endfunction

    task automatic set_line(input int b, input int l, input logic [63:0] d);
        for (int k = 0; k < LANES; k++) mdl[b][l*LANES + k] = d[k*DW +: DW];
    endtask

    task automatic a_xfer(input logic we, input int b, input int l, input logic [63:0] d);
        int n = 0;
        bus_if.a_valid = 1'b1;
        bus_if.a_we    = we;
        bus_if.a_bank  = 2'(b);
        bus_if.a_line  = 4'(l);
        bus_if.a_wdata = d;
        #1;
        while (!bus_if.a_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("a_accept_in_budget", 64'(n < 20), 1);
        @(negedge clk);
        bus_if.a_valid = 1'b0;
    endtask

    task automatic a_write(input int b, input int l, input logic [63:0] d);
        a_xfer(1'b1, b, l, d);
        set_line(b, l, d);
    endtask

    task automatic a_read(input int b, input int l);
        a_xfer(1'b0, b, l, '0);
        check("a_rvalid", bus_if.a_rvalid, 1);
        check("a_rdata", bus_if.a_rdata, mline(b, l));
        @(negedge clk);
        check("a_rvalid_pulse", bus_if.a_rvalid, 0);
    endtask

    task automatic b_read(input int b, input int a);
        bus_if.re_b = 4'b0001 << b;
        bus_if.addr_b[b*AW +: AW] = 6'(a);
        @(negedge clk);
        bus_if.re_b = '0;
        check("b_rvalid", bus_if.rvalid_b[b], 1);
        check("b_rdata", bus_if.rdata_b[b*DW +: DW], mdl[b][a]);
    endtask

    task automatic c_op(input logic first, input int b, input int a, input logic [DW-1:0] d);
        bus_if.c_valid = 1'b1;
        bus_if.c_first = first;
        bus_if.c_bank  = 2'(b);
        bus_if.c_addr  = 6'(a);
        bus_if.c_data  = d;
        mdl[b][a] = first ? d : sat_add(mdl[b][a], d);
        @(negedge clk);
        bus_if.c_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus_if.c_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("c_idle_in_budget", 64'(n < 50), 1);
    endtask

    initial begin
        logic [63:0] d;
        int busy_cnt;

        rst_n = 1'b1;
        bus_if.a_valid = 0; bus_if.a_we = 0; bus_if.a_bank = 0; bus_if.a_line = 0;
        bus_if.a_wdata = 0; bus_if.re_b = 0; bus_if.addr_b = 0;
        bus_if.c_valid = 0; bus_if.c_first = 0; bus_if.c_bank = 0; bus_if.c_addr = 0;
        bus_if.c_data = 0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_a_ready", bus_if.a_ready, 0);
        check("rst_a_rvalid", bus_if.a_rvalid, 0);
        check("rst_rvalid_b", bus_if.rvalid_b, 0);
        check("rst_c_busy", bus_if.c_busy, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // fill every line with random data so the model is fully defined
        for (int b = 0; b < NB; b++)
            for (int l = 0; l < DEPTH / LANES; l++)
                a_write(b, l, {$urandom, $urandom});

        // reset during C1: nothing reaches memory, all outputs clear
        a_read(0, 1);
        b_read(0, 5);
        bus_if.c_valid = 1'b1; bus_if.c_first = 1'b1; bus_if.c_bank = 0;
        bus_if.c_addr = 6'd5; bus_if.c_data = 16'h1234;
        @(posedge clk); #1;
        check("t1_busy_before_rst", bus_if.c_busy, 1);
        bus_if.c_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t1_a_ready", bus_if.a_ready, 0);
        check("t1_a_rvalid", bus_if.a_rvalid, 0);
        check("t1_a_rdata", bus_if.a_rdata, 0);
        check("t1_rvalid_b", bus_if.rvalid_b, 0);
        check("t1_rdata_b", bus_if.rdata_b, 0);
        check("t1_c_busy", bus_if.c_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b_read(0, 5);

        // line write then element reads, one cycle latency
        a_write(2, 3, 64'h0004_0003_0002_0001);
        for (int i = 0; i < 4; i++) begin
            bus_if.re_b = 4'b0100;
            bus_if.addr_b[2*AW +: AW] = 6'(12 + i);
            @(negedge clk);
            check("t2_rvalid", bus_if.rvalid_b[2], 1);
            check("t2_rdata", bus_if.rdata_b[2*DW +: DW], 64'(i + 1));
        end
        bus_if.re_b = '0;
        @(negedge clk);
        check("t2_rvalid_drop", bus_if.rvalid_b[2], 0);
        check("t2_rdata_hold", bus_if.rdata_b[2*DW +: DW], 64'h4);

        // back-to-back accumulates at one address exercise forwarding
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            bus_if.c_valid = 1'b1; bus_if.c_first = (i == 0); bus_if.c_bank = 2'd3;
            bus_if.c_addr = 6'd9; bus_if.c_data = (i == 0) ? 16'd5 : 16'd1;
            @(negedge clk);
            if (bus_if.c_busy) busy_cnt++;
        end
        bus_if.c_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.c_busy) busy_cnt++;
        end
        check("t3_busy_cycles", 64'(busy_cnt), 6);
        mdl[3][9] = 16'd9;
        b_read(3, 9);
        check("t3_final_value", bus_if.rdata_b[3*DW +: DW], 16'd9);

        // saturation both directions
        c_op(1'b1, 1, 30, 16'h7FF0);
        c_op(1'b0, 1, 30, 16'h0100);
        c_op(1'b1, 1, 31, 16'h8010);
        c_op(1'b0, 1, 31, 16'hFF00);
        wait_idle();
        b_read(1, 30);
        check("t4_sat_pos", bus_if.rdata_b[1*DW +: DW], 16'h7FFF);
        b_read(1, 31);
        check("t4_sat_neg", bus_if.rdata_b[1*DW +: DW], 16'h8000);

        // C2 write blocks port A on the same bank only
        c_op(1'b1, 1, 7, 16'h0ABC);
        @(negedge clk);
        d = {$urandom, $urandom};
        bus_if.a_valid = 1'b1; bus_if.a_we = 1'b1; bus_if.a_bank = 2'd1;
        bus_if.a_line = 4'd5; bus_if.a_wdata = d;
        #1 check("t5_aready_blocked", bus_if.a_ready, 0);
        @(negedge clk);
        #1 check("t5_aready_next", bus_if.a_ready, 1);
        @(negedge clk);
        bus_if.a_valid = 1'b0;
        set_line(1, 5, d);
        c_op(1'b1, 1, 8, 16'h0DEF);
        @(negedge clk);
        d = {$urandom, $urandom};
        bus_if.a_valid = 1'b1; bus_if.a_we = 1'b1; bus_if.a_bank = 2'd0;
        bus_if.a_line = 4'd6; bus_if.a_wdata = d;
        #1 check("t5_aready_other_bank", bus_if.a_ready, 1);
        @(negedge clk);
        bus_if.a_valid = 1'b0;
        set_line(0, 6, d);
        wait_idle();
        b_read(1, 7);
        b_read(1, 8);
        b_read(1, 20);
        b_read(0, 24);

        // all banks read element 8 while port A rewrites bank0 line2
        d = {$urandom, $urandom};
        bus_if.re_b = 4'hF;
        bus_if.addr_b = {4{6'd8}};
        bus_if.a_valid = 1'b1; bus_if.a_we = 1'b1; bus_if.a_bank = 2'd0;
        bus_if.a_line = 4'd2; bus_if.a_wdata = d;
        #1 check("t6_aready", bus_if.a_ready, 1);
        @(negedge clk);
        bus_if.re_b = '0;
        bus_if.a_valid = 1'b0;
        for (int b = 0; b < NB; b++) begin
            check("t6_rvalid", bus_if.rvalid_b[b], 1);
            check("t6_rdata_old", bus_if.rdata_b[b*DW +: DW], mdl[b][8]);
        end
        set_line(0, 2, d);
        b_read(0, 8);

        // randomized accumulate traffic on a few hot addresses
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            c_op($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 16'($urandom));
        end
        wait_idle();

        for (int a = 0; a < DEPTH; a++) begin
            bus_if.re_b = 4'hF;
            for (int b = 0; b < NB; b++) bus_if.addr_b[b*AW +: AW] = 6'(a);
            @(negedge clk);
            for (int b = 0; b < NB; b++)
                check("rand_readback", bus_if.rdata_b[b*DW +: DW], mdl[b][a]);
        end
        bus_if.re_b = '0;
        for (int i = 0; i < 10; i++)
            a_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
